// File: rtl/cellrv32_bus_responder.sv
// cellrv32_bus_responder: peripheral-side responder for the CELLRV32 internal bus.
// Serves a word-addressed scratch RAM window with a fixed number of wait states.
// Every accepted request gets exactly one ack or one err.
// Optional user-mode write protection of the lowest PROT_WORDS words is
// enabled by defining the macro CELLRV32_BUS_RESP_PROT_EN.
module cellrv32_bus_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 1,
    parameter int          PROT_WORDS  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_priv_i,
    input  logic        bus_cached_i,
    input  logic        bus_src_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic [3:0]  bus_ben_i,
    input  logic        bus_we_i,
    input  logic        bus_re_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_ack_o,
    output logic        bus_err_o,
    output logic        busy_o,
    output logic        last_src_o
);

    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_MASK_C = ~(32'(MEM_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Merge new write data into an old word, one byte lane per enable bit.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  ben);
        logic [31:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (ben[n]) begin
                res[8*n +: 8] = new_w[8*n +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]      mem_r [MEM_WORDS];
    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [31:0]      wdata_r;
    logic [3:0]       ben_r;
    logic             we_r;
    logic             re_r;
    logic             priv_r;
    logic             ack_r;
    logic             err_r;
    logic [31:0]      rdata_r;
    logic             busy_r;
    logic             src_r;

    logic             hit_s;
    logic             accept_s;
    logic [IDX_W-1:0] idx_s;
    logic             we_s;
    logic             re_s;
    logic             priv_s;
    logic             resp_err_s;
    logic [31:0]      resp_rdata_s;
    logic             unused_s;

    // Decode the window and select the request that the response is built from:
    // the live bus inputs when accepting straight into RESP, else the latched copy.
    always_comb begin
        hit_s        = ((bus_addr_i & WIN_MASK_C) == BASE_ADDR);
        accept_s     = (state_r == ST_IDLE) && hit_s && (bus_re_i || bus_we_i);
        idx_s        = idx_r;
        we_s         = we_r;
        re_s         = re_r;
        priv_s       = priv_r;
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'd0;
        if (state_r == ST_IDLE) begin
            idx_s  = bus_addr_i[IDX_W+1:2];
            we_s   = bus_we_i;
            re_s   = bus_re_i;
            priv_s = bus_priv_i;
        end else begin
            idx_s  = idx_r;
            we_s   = we_r;
            re_s   = re_r;
            priv_s = priv_r;
        end
        resp_err_s = re_s && we_s;
`ifdef CELLRV32_BUS_RESP_PROT_EN
        if (we_s && !priv_s && ({{(32-IDX_W){1'b0}}, idx_s} < 32'(PROT_WORDS))) begin
            resp_err_s = 1'b1;
        end else begin
            resp_err_s = resp_err_s;
        end
`endif
        if (re_s && !resp_err_s) begin
            resp_rdata_s = mem_r[idx_s];
        end else begin
            resp_rdata_s = 32'd0;
        end
        unused_s = ^{bus_cached_i, priv_s, priv_r};
    end

    // Request FSM with registered response, busy and source outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            ben_r   <= 4'd0;
            we_r    <= 1'b0;
            re_r    <= 1'b0;
            priv_r  <= 1'b0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
            busy_r  <= 1'b0;
            src_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_r   <= bus_addr_i[IDX_W+1:2];
                        wdata_r <= bus_wdata_i;
                        ben_r   <= bus_ben_i;
                        we_r    <= bus_we_i;
                        re_r    <= bus_re_i;
                        priv_r  <= bus_priv_i;
                        src_r   <= bus_src_i;
                        cnt_r   <= 4'(WAIT_STATES);
                        busy_r  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_r <= ST_RESP;
                            ack_r   <= !resp_err_s;
                            err_r   <= resp_err_s;
                            rdata_r <= resp_rdata_s;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                        ack_r   <= !resp_err_s;
                        err_r   <= resp_err_s;
                        rdata_r <= resp_rdata_s;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'd0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                    rdata_r <= 32'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // RAM write at the end of an acknowledged write's RESP cycle; a reset before
    // then returns the FSM to IDLE and the write never happens.
    always_ff @(posedge clk_i) begin
        if ((state_r == ST_RESP) && ack_r && we_r) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], wdata_r, ben_r);
        end
    end

    assign bus_ack_o   = ack_r;
    assign bus_err_o   = err_r;
    assign bus_rdata_o = rdata_r;
    assign busy_o      = busy_r;
    assign last_src_o  = src_r;

endmodule

// File: tb/tb_cellrv32_bus_responder.sv
// Directed scoreboard bench for cellrv32_bus_responder (WAIT_STATES = 1).
module tb_cellrv32_bus_responder;

    localparam int WS = 1;
`ifdef CELLRV32_BUS_RESP_PROT_EN
    localparam bit PROT_C = 1'b1;
`else
    localparam bit PROT_C = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        priv = 1'b1;
    logic        cached = 1'b0;
    logic        src = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  ben = 4'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic        last_src;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [256];
    int          checks = 0;
    int          errors = 0;

    cellrv32_bus_responder #(
        .BASE_ADDR  (32'h8000_0000),
        .MEM_WORDS  (256),
        .WAIT_STATES(WS),
        .PROT_WORDS (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_priv_i  (priv),
        .bus_cached_i(cached),
        .bus_src_i   (src),
        .bus_addr_i  (addr),
        .bus_wdata_i (wdata),
        .bus_ben_i   (ben),
        .bus_we_i    (we),
        .bus_re_i    (re),
        .bus_rdata_o (rdata),
        .bus_ack_o   (ack),
        .bus_err_o   (err),
        .busy_o      (busy),
        .last_src_o  (last_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one hit request, model it, push expectation, then pop on response.
    task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic p, input logic s);
        exp_t        e;
        exp_t        got;
        logic [7:0]  idx;
        logic [31:0] nw;
        int          lat;
        bit          seen;
        idx     = a[9:2];
        e.err   = (r && w) || (PROT_C && w && !p && (idx < 8'd16));
        e.ack   = !e.err;
        e.rdata = (r && !e.err) ? mem_m[idx] : 32'd0;
        if (w && !e.err) begin
            nw = mem_m[idx];
            for (int n = 0; n < 4; n++) begin
                if (b[n]) nw[8*n +: 8] = d[8*n +: 8];
            end
            mem_m[idx] = nw;
        end
        sb_q.push_back(e);
        @(negedge clk);
        re = r; we = w; addr = a; wdata = d; ben = b; priv = p; src = s;
        @(posedge clk);
        #1;
        re = 1'b0; we = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_t1", {31'd0, busy}, 32'd1);
            if (ack || err) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        check("resp_seen", {31'd0, seen}, 32'd1);
        got = sb_q.pop_front();
        if (seen) begin
            check("latency", lat, WS + 1);
            check("ack", {31'd0, ack}, {31'd0, got.ack});
            check("err", {31'd0, err}, {31'd0, got.err});
            check("rdata", rdata, got.rdata);
            check("busy_resp", {31'd0, busy}, 32'd1);
            check("last_src", {31'd0, last_src}, {31'd0, s});
        end
        @(negedge clk);
        check("post_ack", {31'd0, ack}, 32'd0);
        check("post_err", {31'd0, err}, 32'd0);
        check("post_rdata", rdata, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_src", {31'd0, last_src}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read latency with preloaded word 4, reported source B.
        xfer(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'hF, 1'b1, 1'b1);

        // Partial byte-lane write, read with ben ignored.
        xfer(1'b0, 1'b1, 32'h8000_0020, 32'h0000_0000, 4'hF, 1'b1, 1'b0);
        xfer(1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'b0101, 1'b1, 1'b1);
        xfer(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'b0001, 1'b1, 1'b0);
        check("lane_model", mem_m[8], 32'h0022_0044);

        // Miss: ignored completely for 20 cycles, then a hit is served.
        @(negedge clk);
        re = 1'b1; addr = 32'h9000_0000; src = 1'b1;
        @(posedge clk);
        #1;
        re = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("miss_quiet", {29'd0, ack, err, busy}, 32'd0);
        end
        check("miss_src", {31'd0, last_src}, 32'd0);
        xfer(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'hF, 1'b0, 1'b0);

        // re+we together -> err, word 0 unchanged.
        xfer(1'b0, 1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'hF, 1'b1, 1'b0);
        xfer(1'b1, 1'b1, 32'h8000_0000, 32'h0BAD_0BAD, 4'hF, 1'b1, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0000, 32'd0, 4'hF, 1'b1, 1'b0);

        // ben = 0 write acks with no change.
        xfer(1'b0, 1'b1, 32'h8000_0010, 32'h1111_1111, 4'h0, 1'b1, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'hF, 1'b1, 1'b0);

        // User write to a low word, then machine write to it.
        xfer(1'b0, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        xfer(1'b0, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0004, 32'd0, 4'hF, 1'b0, 1'b0);
        xfer(1'b0, 1'b1, 32'h8000_0004, 32'h8765_4321, 4'hF, 1'b1, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0004, 32'd0, 4'hF, 1'b0, 1'b0);
        // User write above the protected range is always acked.
        xfer(1'b0, 1'b1, 32'h8000_0100, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 32'h8000_0100, 32'd0, 4'hF, 1'b0, 1'b0);

        // Reset during WAIT of a write to word 2 discards it.
        xfer(1'b0, 1'b1, 32'h8000_0008, 32'h0BAD_0002, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        we = 1'b1; addr = 32'h8000_0008; wdata = 32'hFFFF_FFFF; ben = 4'hF; src = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rst_mid_quiet", {29'd0, ack, err, busy}, 32'd0);
        end
        xfer(1'b1, 1'b0, 32'h8000_0008, 32'd0, 4'hF, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
